// File: rtl/dsp_cal_pkg.sv
// Shared types and constants for the ADC offset calibration controller.
package dsp_cal_pkg;

  localparam int unsigned SAMPLE_W = 24;
  localparam int unsigned OFFSET_W = 64;
  localparam int unsigned FRAC_W   = 8;

  // 2.135 V expressed in the 24-bit sample field at [31:8]
  localparam logic [OFFSET_W-1:0] DEFAULT_OFFSET = 64'h00000000AACCCCCD;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_ACCUM  = 2'd2,
    ST_LOAD   = 2'd3
  } cal_state_e;

endpackage

// File: rtl/offset_cal_ctrl_if.sv
// Control, sample and result signals of the offset calibration controller.
interface offset_cal_ctrl_if
  import dsp_cal_pkg::*;
;
  logic                start;
  logic                abort;
  logic                sample_valid;
  logic [SAMPLE_W-1:0] in1;
  logic [OFFSET_W-1:0] offset_out;
  logic                busy;
  logic                done;
  logic                cal_err;

  modport master (
    output start, abort, sample_valid, in1,
    input  offset_out, busy, done, cal_err
  );

  modport slave (
    input  start, abort, sample_valid, in1,
    output offset_out, busy, done, cal_err
  );
endinterface

// File: rtl/cal_sample_accum.sv
// Clearable sample accumulator plus valid-sample counter for the calibration FSM.
module cal_sample_accum
  import dsp_cal_pkg::*;
#(
  parameter int unsigned ACC_W = 32,
  parameter int unsigned CNT_W = 9
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clr,
  input  logic                cnt_en,
  input  logic                acc_en,
  input  logic [SAMPLE_W-1:0] sample,
  output logic [ACC_W-1:0]    acc,
  output logic [CNT_W-1:0]    cnt
);

  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Clear has priority; otherwise add the zero-extended sample and bump the count
  always_comb begin
    acc_d = acc_q;
    cnt_d = cnt_q;
    if (clr) begin
      acc_d = '0;
      cnt_d = '0;
    end else begin
      if (acc_en) acc_d = acc_q + ACC_W'(sample);
      if (cnt_en) cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Accumulator and counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q <= '0;
      cnt_q <= '0;
    end else begin
      acc_q <= acc_d;
      cnt_q <= cnt_d;
    end
  end

  assign acc = acc_q;
  assign cnt = cnt_q;

endmodule

// File: rtl/offset_cal_ctrl.sv
// ADC offset calibration controller: discards settle samples, averages 2^LOG2_N
// samples and publishes the mean (8 fraction bits) as the subtract-datapath offset.
// Optional watchdog enabled by defining OFFSET_CAL_TIMEOUT_EN.
module offset_cal_ctrl
  import dsp_cal_pkg::SAMPLE_W, dsp_cal_pkg::OFFSET_W, dsp_cal_pkg::FRAC_W,
         dsp_cal_pkg::cal_state_e, dsp_cal_pkg::ST_IDLE, dsp_cal_pkg::ST_SETTLE,
         dsp_cal_pkg::ST_ACCUM, dsp_cal_pkg::ST_LOAD;
#(
  parameter int unsigned         LOG2_N         = 8,
  parameter int unsigned         SETTLE_SAMPLES = 4,
  parameter logic [OFFSET_W-1:0] DEFAULT_OFFSET = dsp_cal_pkg::DEFAULT_OFFSET,
  parameter int unsigned         TIMEOUT_CYCLES = 4096
) (
  input logic               clk,
  input logic               rst,
  offset_cal_ctrl_if.slave  bus
);

  localparam int unsigned ACC_W  = SAMPLE_W + LOG2_N;
  localparam int unsigned CNT_W  = LOG2_N + 1;
  localparam int unsigned MEAN_W = SAMPLE_W + FRAC_W;
  localparam logic [CNT_W-1:0] ACCUM_LAST  = CNT_W'((1 << LOG2_N) - 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST =
    CNT_W'((SETTLE_SAMPLES == 0) ? 0 : SETTLE_SAMPLES - 1);
  // An out-of-range configuration never leaves IDLE
  localparam bit PARAMS_OK = (LOG2_N >= 8) && (LOG2_N <= 16) &&
                             (SETTLE_SAMPLES <= 255) && (TIMEOUT_CYCLES > 0);

  cal_state_e           state_q, state_d;
  logic [OFFSET_W-1:0]  offset_q, offset_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 cal_err_q, cal_err_d;
  logic                 clr_c, cnt_en_c, acc_en_c;
  logic [ACC_W-1:0]     acc;
  logic [CNT_W-1:0]     cnt;

`ifdef OFFSET_CAL_TIMEOUT_EN
  localparam int unsigned WD_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(TIMEOUT_CYCLES);
  logic [WD_W-1:0] wdog_q, wdog_d;
`endif

  cal_sample_accum #(
    .ACC_W (ACC_W),
    .CNT_W (CNT_W)
  ) u_accum (
    .clk    (clk),
    .rst    (rst),
    .clr    (clr_c),
    .cnt_en (cnt_en_c),
    .acc_en (acc_en_c),
    .sample (bus.in1),
    .acc    (acc),
    .cnt    (cnt)
  );

  // Next-state, datapath control and registered-output values
  always_comb begin
    state_d   = state_q;
    offset_d  = offset_q;
    done_d    = 1'b0;
    cal_err_d = 1'b0;
    clr_c     = 1'b0;
    cnt_en_c  = 1'b0;
    acc_en_c  = 1'b0;
`ifdef OFFSET_CAL_TIMEOUT_EN
    wdog_d    = '0;
`endif

    unique case (state_q)
      ST_IDLE: begin
        if (bus.start && !bus.abort && PARAMS_OK) begin
          clr_c   = 1'b1;
          state_d = (SETTLE_SAMPLES == 0) ? ST_ACCUM : ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        if (bus.abort) begin
          state_d = ST_IDLE;
        end else if (bus.sample_valid) begin
          cnt_en_c = 1'b1;
          if (cnt == SETTLE_LAST) begin
            clr_c   = 1'b1;
            state_d = ST_ACCUM;
          end
        end
      end
      ST_ACCUM: begin
        if (bus.abort) begin
          state_d = ST_IDLE;
        end else if (bus.sample_valid) begin
          cnt_en_c = 1'b1;
          acc_en_c = 1'b1;
          if (cnt == ACCUM_LAST) state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        offset_d = {(OFFSET_W - MEAN_W)'(0), acc[ACC_W-1 -: MEAN_W]};
        done_d   = 1'b1;
        state_d  = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

`ifdef OFFSET_CAL_TIMEOUT_EN
    // Count consecutive sample-less cycles while waiting for data
    if ((state_q == ST_SETTLE || state_q == ST_ACCUM) && !bus.abort &&
        !bus.sample_valid) begin
      wdog_d = wdog_q + WD_W'(1);
      if (wdog_d == WD_LIMIT) begin
        wdog_d    = '0;
        cal_err_d = 1'b1;
        state_d   = ST_IDLE;
      end
    end
`endif

    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      offset_q  <= DEFAULT_OFFSET;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      cal_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      offset_q  <= offset_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      cal_err_q <= cal_err_d;
    end
  end

`ifdef OFFSET_CAL_TIMEOUT_EN
  // Watchdog counter register
  always_ff @(posedge clk) begin
    if (rst) wdog_q <= '0;
    else     wdog_q <= wdog_d;
  end
`endif

  assign bus.offset_out = offset_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.cal_err    = cal_err_q;

endmodule

// File: tb/tb_offset_cal_ctrl.sv
// Directed self-checking bench for offset_cal_ctrl (LOG2_N=8, SETTLE_SAMPLES=4).
// Define OFFSET_CAL_TIMEOUT_EN to also exercise the watchdog (TIMEOUT_CYCLES=16).
module tb_offset_cal_ctrl;

  localparam logic [63:0] DEF_OFF = 64'h00000000AACCCCCD;

  logic clk = 1'b0;
  logic rst;
  int   n_vec = 0;
  int   n_err = 0;

  offset_cal_ctrl_if bus ();

  offset_cal_ctrl #(
    .LOG2_N         (8),
    .SETTLE_SAMPLES (4),
    .DEFAULT_OFFSET (DEF_OFF),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One rising edge; outputs are sampled 1 time unit after it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int n, input logic [23:0] v);
    for (int i = 0; i < n; i++) begin
      bus.sample_valid = 1'b1;
      bus.in1          = v;
      tick();
    end
    bus.sample_valid = 1'b0;
  endtask

  task automatic do_start();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  initial begin
    rst              = 1'b1;
    bus.start        = 1'b0;
    bus.abort        = 1'b0;
    bus.sample_valid = 1'b0;
    bus.in1          = '0;
    tick();
    tick();
    rst = 1'b0;
    chk("rst_offset", bus.offset_out, DEF_OFF);
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_done", 64'(bus.done), 64'd0);
    chk("rst_cal_err", 64'(bus.cal_err), 64'd0);

    // Samples in IDLE are ignored
    send(3, 24'h123456);
    chk("idle_sample_busy", 64'(bus.busy), 64'd0);
    chk("idle_sample_offset", bus.offset_out, DEF_OFF);

    // Abort after 100 accumulated samples
    do_start();
    chk("start_busy", 64'(bus.busy), 64'd1);
    send(4, 24'h000010);
    send(100, 24'h0F0F0F);
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    chk("abort_busy", 64'(bus.busy), 64'd0);
    chk("abort_done", 64'(bus.done), 64'd0);
    chk("abort_offset", bus.offset_out, DEF_OFF);
    tick();
    chk("abort_done_after", 64'(bus.done), 64'd0);

    // Restart: 260 samples of AACCCC
    do_start();
    send(259, 24'hAACCCC);
    chk("c1_busy_mid", 64'(bus.busy), 64'd1);
    send(1, 24'hAACCCC);
    chk("c1_done_edge1", 64'(bus.done), 64'd0);
    chk("c1_offset_edge1", bus.offset_out, DEF_OFF);
    tick();
    chk("c1_done_edge2", 64'(bus.done), 64'd1);
    chk("c1_offset", bus.offset_out, 64'h00000000AACCCC00);
    chk("c1_busy_end", 64'(bus.busy), 64'd0);
    tick();
    chk("c1_done_pulse", 64'(bus.done), 64'd0);
    chk("c1_offset_hold", bus.offset_out, 64'h00000000AACCCC00);

    // FFFFFF settle samples, then 1/2 alternating with gaps; abort in LOAD ignored
    do_start();
    send(2, 24'hFFFFFF);
    tick();
    send(2, 24'hFFFFFF);
    for (int i = 0; i < 256; i++) begin
      send(1, (i % 2 == 0) ? 24'h000001 : 24'h000002);
      if (i % 37 == 5) begin
        bus.in1 = 24'hFFFFFF;
        tick();
      end
    end
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    chk("c2_done", 64'(bus.done), 64'd1);
    chk("c2_offset", bus.offset_out, 64'h0000000000000180);
    tick();

`ifdef OFFSET_CAL_TIMEOUT_EN
    // Watchdog: stall sample_valid in ACCUM
    do_start();
    send(4, 24'h000100);
    send(10, 24'h000100);
    for (int i = 1; i <= 15; i++) tick();
    chk("wd_err_early", 64'(bus.cal_err), 64'd0);
    chk("wd_busy_early", 64'(bus.busy), 64'd1);
    tick();
    chk("wd_err", 64'(bus.cal_err), 64'd1);
    chk("wd_busy", 64'(bus.busy), 64'd0);
    chk("wd_offset", bus.offset_out, 64'h0000000000000180);
    tick();
    chk("wd_err_pulse", 64'(bus.cal_err), 64'd0);
`else
    // Without the watchdog a long stall keeps the calibration pending
    do_start();
    send(4, 24'h000100);
    send(10, 24'h000100);
    for (int i = 0; i < 40; i++) tick();
    chk("stall_busy", 64'(bus.busy), 64'd1);
    chk("stall_cal_err", 64'(bus.cal_err), 64'd0);
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    chk("stall_abort_busy", 64'(bus.busy), 64'd0);
`endif

    // Reset mid-ACCUM after a prior calibration
    do_start();
    send(4, 24'h000100);
    send(50, 24'h000100);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_offset", bus.offset_out, DEF_OFF);
    chk("midrst_busy", 64'(bus.busy), 64'd0);

    // Start together with abort in IDLE stays IDLE
    bus.start = 1'b1;
    bus.abort = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.abort = 1'b0;
    chk("start_abort_busy", 64'(bus.busy), 64'd0);
    send(300, 24'h000100);
    chk("start_abort_idle", 64'(bus.busy), 64'd0);
    chk("start_abort_done", 64'(bus.done), 64'd0);
    chk("start_abort_offset", bus.offset_out, DEF_OFF);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/offset_cal_ctrl.md
OFFSET_CAL_CTRL -- requirements
Module: offset_cal_ctrl

Interface
REQ-001 Parameter LOG2_N, default 8: log2 of the number of samples averaged per calibration; legal range 8..16.
REQ-002 Parameter SETTLE_SAMPLES, default 4: valid samples discarded before accumulation starts; legal range 0..255.
REQ-003 Parameter DEFAULT_OFFSET, default 64'h00000000AACCCCCD: offset value presented after reset (2.135 V, 24-bit sample field at [31:8]).
REQ-004 Parameter TIMEOUT_CYCLES, default 4096: watchdog limit in clk cycles; used only when the watchdog macro is defined.
REQ-005 clk  in  1  single clock; all logic on its rising edge.
REQ-006 rst  in  1  synchronous, active-high reset.
REQ-007 start  in  1  one-cycle request to begin a calibration.
REQ-008 abort  in  1  cancels a calibration in progress.
REQ-009 sample_valid  in  1  in1 holds a new ADC sample this cycle.
REQ-010 in1  in  24  ADC sample; treated as unsigned, as in the subtract datapath.
REQ-011 offset_out  out  64  offset word driving the subtract datapath.
REQ-012 busy  out  1  high in every state except IDLE.
REQ-013 done  out  1  one-cycle pulse when a new offset_out is published.
REQ-014 cal_err  out  1  one-cycle pulse on watchdog abort.

Function
REQ-015 FSM states: IDLE, SETTLE, ACCUM, LOAD; state register is a one-hot or binary encoding from the package.
REQ-016 IDLE->SETTLE when start=1 and abort=0; go to ACCUM instead if SETTLE_SAMPLES=0; start in any other state is ignored.
REQ-017 SETTLE: count valid samples; move to ACCUM on the cycle the SETTLE_SAMPLES-th valid sample is taken; do not accumulate.
REQ-018 ACCUM: on each valid sample, acc += in1 (zero-extended); acc is unsigned, 24+LOG2_N bits, and is cleared on entry.
REQ-019 ACCUM->LOAD on the cycle the 2^LOG2_N-th valid sample is accumulated; that sample is included.
REQ-020 LOAD: on the next edge, set offset_out[63:32]=0 and offset_out[31:0]=acc[LOG2_N+23 : LOG2_N-8] (mean with 8 fraction bits); done=1 for exactly that cycle; then go to IDLE.
REQ-021 Latency: offset_out and done change 2 edges after the final sample edge; there is no overflow, by construction of the acc width.
REQ-022 abort=1 in SETTLE or ACCUM: go to IDLE on the next edge; offset_out unchanged; no done pulse.
REQ-023 abort in LOAD is ignored (publish completes); abort in IDLE wins over a simultaneous start.
REQ-024 sample_valid outside SETTLE/ACCUM is ignored; offset_out holds its value between calibrations.

Reset
REQ-025 On rst: state=IDLE, acc=0, counters=0, offset_out=DEFAULT_OFFSET, busy=0, done=0, cal_err=0.
REQ-026 rst mid-calibration discards the partial result; offset_out returns to DEFAULT_OFFSET on the next edge.

Configuration
REQ-027 Macro OFFSET_CAL_TIMEOUT_EN: when defined, a watchdog counts consecutive cycles with sample_valid=0 in SETTLE/ACCUM and clears on each valid sample.
REQ-028 When the count reaches TIMEOUT_CYCLES: go to IDLE, pulse cal_err for 1 cycle, leave offset_out unchanged.
REQ-029 When undefined, the block waits indefinitely and cal_err is tied 0.

Structure
REQ-030 Package dsp_cal_pkg holds the FSM state typedef, DEFAULT_OFFSET, SAMPLE_W=24, OFFSET_W=64 and FRAC_W=8.
REQ-031 A single sub-module, cal_sample_accum, holds the clear/enable accumulator and the sample counter; the FSM and watchdog stay in the top module.

Verification
REQ-032 LOG2_N=8, SETTLE=4; start, then 260 valid samples of 24'hAACCCC -> offset_out=64'h00000000AACCCC00 and done=1 two edges after the 260th sample.
REQ-033 Settle samples of 24'hFFFFFF, then 256 samples alternating 24'h000001/24'h000002 -> offset_out=64'h0000000000000180.
REQ-034 Abort after 100 ACCUM samples -> IDLE on the next edge, offset_out stays 64'h00000000AACCCCCD, no done pulse; a restart then completes normally.
REQ-035 OFFSET_CAL_TIMEOUT_EN defined, TIMEOUT_CYCLES=16; stop sample_valid in ACCUM -> cal_err pulses on the 16th idle cycle, busy falls, offset_out unchanged.
REQ-036 rst asserted mid-ACCUM after a prior calibration -> offset_out=DEFAULT_OFFSET and busy=0 on the next edge; start together with abort in IDLE -> remains IDLE.
